// File: rtl/fetch_unit.sv
// Instruction fetch stage: reads 1- or 2-byte instructions from an asynchronous
// memory and delivers them downstream. Optional FETCH_TRACE_EN adds inst_count and handshake trace messages.
module fetch_unit #(
    parameter int                  PC_WIDTH    = 8,
    parameter logic [PC_WIDTH-1:0] RESET_PC    = '0,
    parameter logic [7:0]          HALT_OPCODE = 8'hFF
) (
    input  logic                clk,
    input  logic                rst_n,
    output logic [PC_WIDTH-1:0] inst_address,
    input  logic [7:0]          instruction,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [7:0]          out_opcode,
    output logic [7:0]          out_operand,
    output logic [PC_WIDTH-1:0] out_pc,
    output logic                out_two_byte,
    input  logic                redirect_valid,
    input  logic [PC_WIDTH-1:0] redirect_pc,
    output logic                halted,
    output logic [1:0]          state_dbg
`ifdef FETCH_TRACE_EN
    ,
    output logic [15:0]         inst_count
`endif
);

    typedef enum logic [1:0] {
        FETCH_OP  = 2'd0,
        FETCH_ARG = 2'd1,
        HOLD      = 2'd2,
        HALTED    = 2'd3
    } state_t;

    state_t                state, state_n;
    logic [PC_WIDTH-1:0]   pc, pc_n;
    logic [7:0]            opcode_n, operand_n;
    logic [PC_WIDTH-1:0]   out_pc_n;
    logic                  two_byte_n;
    logic                  handshake;
    logic                  is_two_byte;

    // Handshake: a bundle transfers on a rising edge where out_valid and
    // out_ready are both 1; the bundle is held stable until then.
    assign out_valid    = (state == HOLD);
    assign halted       = (state == HALTED);
    assign handshake    = out_valid && out_ready;
    assign inst_address = pc;
    assign state_dbg    = state;
    assign is_two_byte  = instruction[7] && (instruction != HALT_OPCODE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= FETCH_OP;
            pc           <= RESET_PC;
            out_opcode   <= 8'h00;
            out_operand  <= 8'h00;
            out_pc       <= '0;
            out_two_byte <= 1'b0;
        end else begin
            state        <= state_n;
            pc           <= pc_n;
            out_opcode   <= opcode_n;
            out_operand  <= operand_n;
            out_pc       <= out_pc_n;
            out_two_byte <= two_byte_n;
        end
    end

    always_comb begin
        state_n    = state;
        pc_n       = pc;
        opcode_n   = out_opcode;
        operand_n  = out_operand;
        out_pc_n   = out_pc;
        two_byte_n = out_two_byte;
        case (state)
            FETCH_OP: begin
                opcode_n = instruction;
                out_pc_n = pc;
                pc_n     = pc + PC_WIDTH'(1);
                if (is_two_byte) begin
                    state_n = FETCH_ARG;
                end else begin
                    operand_n  = 8'h00;
                    two_byte_n = 1'b0;
                    state_n    = HOLD;
                end
            end
            FETCH_ARG: begin
                operand_n  = instruction;
                two_byte_n = 1'b1;
                pc_n       = pc + PC_WIDTH'(1);
                state_n    = HOLD;
            end
            HOLD: begin
                if (out_ready) begin
                    state_n = (out_opcode == HALT_OPCODE) ? HALTED : FETCH_OP;
                end
            end
            HALTED: begin
                state_n = HALTED;
            end
            default: begin
                state_n = FETCH_OP;
            end
        endcase
        // Redirect overrides everything, including a same-cycle handshake or halt.
        if (redirect_valid) begin
            pc_n    = redirect_pc;
            state_n = FETCH_OP;
        end
    end

`ifdef FETCH_TRACE_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inst_count <= 16'h0000;
        end else if (handshake) begin
            if (inst_count != 16'hFFFF) begin
                inst_count <= inst_count + 16'h0001;
            end
`ifndef SYNTHESIS
            $display("fetch_unit: pc=%0h opcode=%02h operand=%02h",
                     out_pc, out_opcode, out_operand);
`endif
        end
    end
`endif

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction fetch stage directly upstream of the decode/execute logic. It drives the instruction-read address port of the asynchronous memory and consumes the combinational instruction byte returned in the same cycle.
- Assembles 1- or 2-byte instructions (opcode plus optional operand) and presents them downstream with a valid/ready handshake.
- Supports PC redirect (jump/branch) from execute, and a halt opcode.

Parameters:
- PC_WIDTH, 8, width of the program counter and of inst_address.
- RESET_PC, 8'h00, PC value loaded on reset.
- HALT_OPCODE, 8'hFF, opcode that stops fetching once it has been delivered.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- inst_address  output  PC_WIDTH  instruction address to memory; equals the registered pc.
- instruction  input  8  byte read from memory at inst_address, valid in the same cycle.
- out_valid  output  1  instruction bundle valid.
- out_ready  input  1  downstream accepts the bundle.
- out_opcode  output  8  opcode byte.
- out_operand  output  8  operand byte; 8'h00 for 1-byte instructions.
- out_pc  output  PC_WIDTH  address of the opcode byte.
- out_two_byte  output  1  bundle carries an operand.
- redirect_valid  input  1  load a new PC.
- redirect_pc  input  PC_WIDTH  redirect target.
- halted  output  1  fetch is stopped after HALT_OPCODE.

Behaviour:
- Clocking and reset: one clock, clk. Reset is asynchronous and active-low on rst_n.
- Reset values: pc=RESET_PC, state=FETCH_OP, out_valid=0, out_opcode=0, out_operand=0, out_pc=0, out_two_byte=0, halted=0.
- Encoding rule: opcode bit 7 = 1 means a 2-byte instruction. HALT_OPCODE (8'hFF) is the exception: it is always 1-byte.
- State FETCH_OP:
  - Capture instruction into out_opcode and pc into out_pc; pc <= pc+1.
  - If the instruction is 2-byte, go to FETCH_ARG.
  - Otherwise set out_operand=0 and out_two_byte=0, then go to HOLD.
- State FETCH_ARG: capture instruction into out_operand, set out_two_byte=1, pc <= pc+1, go to HOLD.
- State HOLD:
  - out_valid=1. Bundle outputs stay stable until the handshake.
  - On out_ready=1: deassert out_valid next cycle. Go to HALTED if out_opcode==HALT_OPCODE, else go to FETCH_OP.
- State HALTED:
  - halted=1, out_valid=0, pc frozen, inst_address held.
  - Leaves only on redirect.
- Latency: a 1-byte instruction reaches out_valid 1 cycle after entering FETCH_OP; a 2-byte instruction takes 2 cycles. Throughput is one 1-byte instruction per 2 cycles at out_ready=1.
- PC arithmetic: modulo 2^PC_WIDTH; 8'hFF+1 wraps to 8'h00. A 2-byte opcode at 8'hFF takes its operand from 8'h00.
- Redirect, in any state:
  - On redirect_valid=1: pc <= redirect_pc, state <= FETCH_OP, out_valid <= 0, halted <= 0.
  - Any partially assembled instruction is discarded.
- Redirect and handshake in the same cycle (HOLD with out_ready=1 and redirect_valid=1): the handshake completes, so the bundle counts as consumed, and the redirect wins the next state.
- Redirect and HALT in the same cycle: the redirect wins and halted stays 0.
- out_ready while out_valid=0: ignored.
- Reset asserted mid-instruction: all state returns to reset values immediately. No bundle is delivered.
- The block never writes memory; the data port is untouched.

Optional Feature:
- Macro: FETCH_TRACE_EN.
- Defined:
  - Adds output port inst_count, 16 bits, reset 0. It increments on every completed handshake and saturates at 16'hFFFF.
  - Each handshake emits a simulation message with pc, opcode and operand.
- Undefined: port and counter are absent, with no messages. All other behaviour is identical.

Test Plan:
- Reset release with mem[0]=8'h12, out_ready=1 -> inst_address=0 at reset; out_valid high one cycle later with opcode 12, operand 00, out_pc 00, out_two_byte 0.
- Two-byte instruction: mem[0]=8'h85, mem[1]=8'h3C, mem[2]=8'h01 -> bundle {85,3C,pc 00,two_byte 1}; next bundle at out_pc 02.
- Backpressure: out_ready=0 for 5 cycles while in HOLD -> outputs stable, pc stays 01, no fetch advance; out_ready=1 -> next fetch from 01.
- Redirect: redirect_valid with redirect_pc=8'h40 while in FETCH_ARG -> partial instruction dropped; next bundle has out_pc 40.
- Wrap: redirect to 8'hFF, mem[FF]=8'h90, mem[00]=8'hAA -> bundle {90,AA,pc FF}; next fetch at 01.
- Halt: mem[5]=8'hFF reached -> bundle delivered, then halted=1 and out_valid stays 0 for 10 cycles; redirect to 8'h00 clears halted and fetch resumes. With FETCH_TRACE_EN defined, inst_count matches the number of handshakes.
